mul_bcd_display: RTL and testbench
==================================

Name: mul_bcd_display

Overview:
Downstream consumer of the 4x4 array multiplier. Accepts the 8-bit product `p` through a valid/ready handshake. Converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, then time-multiplexes those digits onto the board's 4-digit common-anode 7-segment display. Sits between the multiplier output and the board display pins.

Parameters:
- P_W, 8, product width; fixed at 8, which gives 3 BCD digits.
- SCAN_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  product on `p` is valid.
- in_ready  output  1  converter idle; asserted iff state==IDLE.
- p  input  8  unsigned product from the multiplier.
- out_valid  output  1  one-cycle pulse; bcd updated.
- bcd  output  12  {hundreds, tens, units}, 4 bits each, registered.
- an  output  4  digit enables, active-low; an[3] always 1.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  output  1  decimal point, constant 1 (off).

Behaviour:
- Reset values (synchronous rst=1):
  - state=IDLE, in_ready=1.
  - out_valid=0, bcd=12'h000.
  - Shift and scan counters = 0, digit index = 0.
  - an=4'b1111, seg=7'b1111111.
- FSM states IDLE and CONV:
  - IDLE with in_valid=1 (edge E0): latch p into an 8-bit shift register, clear a 12-bit working BCD register, bit_cnt=0, go to CONV.
  - IDLE with in_valid=0: hold.
  - CONV, edges E1..E8, each edge:
    - Every working digit >=5 gets +3, all digits in parallel on pre-shift values.
    - Then shift {work_bcd, shreg} left by 1; bit_cnt++.
  - On E8 (bit_cnt==7 before increment): bcd <= adjusted-and-shifted result, out_valid <= 1, state <= IDLE.
- Latency: out_valid is high in the cycle following E8, i.e. 8 cycles after the accepting edge. Throughput is one product per 9 cycles (E8 returns to IDLE; next accept is at E9 at the earliest).
- out_valid is high for exactly one cycle per conversion.
- bcd holds its last value until the next conversion completes.
- in_valid while in CONV: ignored, no buffering. The producer must hold `p` until it sees in_ready=1.
- `p` is sampled only at E0. Later changes to `p` do not affect the conversion in flight.
- Arithmetic: maximum input 255 gives 2/5/5. Digit values never exceed 9 and no overflow is possible.
- Reset mid-conversion: abort, then IDLE, bcd=0, in_ready=1 in the cycle after the rst edge.
- Display scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→0 (units, tens, hundreds).
  - an and seg are registered from the index and the bcd value on the same wrap edge.
  - Before the first wrap after reset, the display stays blank.
- Leading-zero blanking:
  - Hundreds digit blanked (seg=7'b1111111) when hundreds==0.
  - Tens digit blanked when hundreds==0 and tens==0.
  - Units always shown.
  - The corresponding an bit is still driven low when a digit is blanked.
- Segment code for digits 0..9, standard active-low: 0 = 7'b1000000, 1 = 7'b1111001, …, 8 = 7'b0000000, 9 = 7'b0010000.
- Display and converter run concurrently. bcd changing mid-scan takes effect at the next slot.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=1'b0, CONV=1'b1).
  - BCD digit width constant (4).
  - Blank-pattern constant 7'b1111111.
  - Digit-to-segment lookup as a function.
- One sub-module, seg7_decode: 4-bit digit plus blank flag in, 7-bit active-low segments out, combinational.
- FSM, double-dabble datapath and scan counter stay in mul_bcd_display.

Test Plan:
- Handshake and latency: rst, then p=8'd255 with in_valid for 1 cycle → in_ready=0 for 8 cycles; out_valid pulses exactly 8 cycles after accept; bcd=12'h255.
- Zero and blanking: p=0 (e.g. 0x9 product 0) → bcd=12'h000. With SCAN_DIV=4, only the units slot shows 7'b1000000; tens and hundreds slots show 7'b1111111.
- Max multiplier product: p=8'd225 (15x15) → bcd=12'h225. p=8'd6 → bcd=12'h006, with tens and hundreds blanked.
- Busy input ignored: accept p=100, then drive p=42 with in_valid=1 on cycles 2–7 → single out_valid, bcd=12'h100. p=42 is accepted only after in_ready returns.
- Reset mid-conversion: accept p=200, assert rst at cycle 4 → no out_valid; bcd=0; in_ready=1 the next cycle. A following p=37 gives bcd=12'h037.
- Scan order: SCAN_DIV=4, bcd=12'h123 → an sequence 1110, 1101, 1011, repeating every 12 cycles with seg=digit 3, 2, 1; an[3]=1 throughout.

Source files
------------

// File: rtl/mul_bcd_display_pkg.sv
// Shared constants for the BCD converter/display: FSM encoding, digit width,
// blank segment pattern and the digit-to-segment lookup.
package mul_bcd_display_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes show nothing.
  function automatic logic [6:0] seg_of_digit(input logic [BCD_W-1:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mul_bcd_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with a blank override.
module seg7_decode
  import mul_bcd_display_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             blank,
  output logic [6:0]       seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_of_digit(digit);
  end

endmodule

// File: rtl/mul_bcd_display.sv
// Accepts an 8-bit product, converts it to BCD with a sequential double-dabble
// engine, and scans the digits onto a 4-digit common-anode 7-segment display.
module mul_bcd_display
  import mul_bcd_display_pkg::*;
#(
  parameter int P_W      = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [P_W-1:0]    p,
  output logic              out_valid,
  output logic [3*BCD_W-1:0] bcd,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [0:0]          state_q, state_d;
  logic [P_W-1:0]      shreg_q, shreg_d;
  logic [3*BCD_W-1:0]  work_q, work_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [3*BCD_W-1:0]  bcd_q, bcd_d;
  logic                out_valid_q, out_valid_d;

  logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [1:0]          digit_idx_q, digit_idx_d;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [3*BCD_W-1:0]  adj;
  logic [3*BCD_W+P_W-1:0] conv_next;
  logic                conv_msb_unused;
  logic                scan_wrap;
  logic [BCD_W-1:0]    dec_digit;
  logic                dec_blank;
  logic [6:0]          dec_seg;

  // Add-3 correction on every digit in parallel, then shift the whole chain.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      adj[i*BCD_W +: BCD_W] = (work_q[i*BCD_W +: BCD_W] >= 4'd5)
                              ? work_q[i*BCD_W +: BCD_W] + 4'd3
                              : work_q[i*BCD_W +: BCD_W];
    end
    {conv_msb_unused, conv_next} = {adj, shreg_q, 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    work_d      = work_q;
    bit_cnt_d   = bit_cnt_q;
    bcd_d       = bcd_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d   = p;
          work_d    = '0;
          bit_cnt_d = 3'd0;
          state_d   = ST_CONV;
        end
      end
      default: begin
        {work_d, shreg_d} = conv_next;
        bit_cnt_d         = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          bcd_d       = conv_next[3*BCD_W+P_W-1 -: 3*BCD_W];
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  assign scan_wrap = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    dec_digit = bcd_q[BCD_W-1:0];
    dec_blank = 1'b0;
    case (digit_idx_q)
      2'd1: begin
        dec_digit = bcd_q[2*BCD_W-1:BCD_W];
        dec_blank = (bcd_q[3*BCD_W-1:BCD_W] == '0);
      end
      2'd2: begin
        dec_digit = bcd_q[3*BCD_W-1:2*BCD_W];
        dec_blank = (bcd_q[3*BCD_W-1:2*BCD_W] == '0);
      end
      default: ;
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (dec_digit),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  // The slot shown at a wrap is the current index; the index then advances.
  always_comb begin
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    an_d        = an_q;
    seg_d       = seg_q;
    if (scan_wrap) begin
      digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
      seg_d       = dec_seg;
      case (digit_idx_q)
        2'd1:    an_d = 4'b1101;
        2'd2:    an_d = 4'b1011;
        default: an_d = 4'b1110;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      work_q      <= '0;
      bit_cnt_q   <= 3'd0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      work_q      <= work_d;
      bit_cnt_q   <= bit_cnt_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;

endmodule

// File: tb/tb_mul_bcd_display.sv
// Self-checking bench for mul_bcd_display: decimal reference model for the
// conversion and a slot-based model of the scanned display (SCAN_DIV = 4).
module tb_mul_bcd_display;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  p;
  logic        out_valid;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks;
  int errors;

  logic [6:0] seg_table [10];

  mul_bcd_display #(.P_W(8), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .out_valid (out_valid),
    .bcd       (bcd),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Slot 0 units, 1 tens, 2 hundreds; leading zeros blanked, units always shown.
  function automatic logic [6:0] model_seg(input int v, input int slot);
    int d;
    if (slot == 2 && v < 100) return 7'b1111111;
    if (slot == 1 && v < 10)  return 7'b1111111;
    d = (slot == 0) ? v % 10 : (slot == 1) ? (v / 10) % 10 : (v / 100) % 10;
    return seg_table[d];
  endfunction

  function automatic logic [3:0] model_an(input int slot);
    logic [3:0] a;
    a = 4'b1111;
    a[slot] = 1'b0;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for in_ready, presents val for one cycle, then reports the
  // number of edges after the accepting edge until out_valid is seen (-1 on timeout).
  task automatic run_conv(input logic [7:0] val, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    p = val;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    p = 8'h00;
    do_reset();
    checks++;
    if ({in_ready, out_valid, bcd, an, seg, dp} !== {1'b1, 1'b0, 12'h000, 4'b1111, 7'b1111111, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state got rdy=%b ov=%b bcd=%h an=%b seg=%b dp=%b", in_ready, out_valid, bcd, an, seg, dp);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({an, seg} !== {4'b1111, 7'b1111111}) begin
      errors++;
      $display("[TB] FAIL blank_before_wrap got an=%b seg=%b want 1111/1111111", an, seg);
    end
    tick();
    checks++;
    if ({an, seg} !== {4'b1110, seg_table[0]}) begin
      errors++;
      $display("[TB] FAIL first_wrap got an=%b seg=%b want 1110/%b", an, seg, seg_table[0]);
    end
  endtask

  task automatic test_handshake_latency();
    int c;
    int lat;
    int busy_bad;
    busy_bad = 0;
    lat = -1;
    p = 8'd255;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (c < 20 && lat < 0) begin
      if (!out_valid && in_ready) busy_bad++;
      tick();
      c++;
      if (out_valid) lat = c;
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("[TB] FAIL busy_ready got %0d ready cycles during conversion want 0", busy_bad);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("[TB] FAIL latency_255 got %0d want 8", lat);
    end
    checks++;
    if (bcd !== 12'h255 || !in_ready) begin
      errors++;
      $display("[TB] FAIL bcd_255 got bcd=%h rdy=%b want 255/1", bcd, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pulse_width got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_scan(input int v);
    logic [3:0] prev;
    int w;
    int bad;
    for (int i = 0; i < 3 * SCAN_DIV + 2; i++) tick();
    prev = an;
    w = 0;
    tick();
    while (!(an == 4'b1110 && prev != 4'b1110) && w < 30) begin
      prev = an;
      tick();
      w++;
    end
    checks++;
    if (w >= 30) begin
      errors++;
      $display("[TB] FAIL scan_sync_%0d got no units slot within 30 cycles", v);
    end
    bad = 0;
    for (int k = 0; k < 3 * SCAN_DIV * 2; k++) begin
      if (an !== model_an((k / SCAN_DIV) % 3) || seg !== model_seg(v, (k / SCAN_DIV) % 3) || an[3] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL scan_%0d k=%0d got an=%b seg=%b want an=%b seg=%b", v, k, an, seg,
                 model_an((k / SCAN_DIV) % 3), model_seg(v, (k / SCAN_DIV) % 3));
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_zero_blanking();
    int lat;
    run_conv(8'd0, lat);
    checks++;
    if (lat !== 8 || bcd !== 12'h000) begin
      errors++;
      $display("[TB] FAIL conv_0 got lat=%0d bcd=%h want 8/000", lat, bcd);
    end
    test_scan(0);
  endtask

  task automatic test_max_and_small();
    int lat;
    run_conv(8'd225, lat);
    checks++;
    if (lat !== 8 || bcd !== 12'h225) begin
      errors++;
      $display("[TB] FAIL conv_225 got lat=%0d bcd=%h want 8/225", lat, bcd);
    end
    run_conv(8'd6, lat);
    checks++;
    if (lat !== 8 || bcd !== 12'h006) begin
      errors++;
      $display("[TB] FAIL conv_6 got lat=%0d bcd=%h want 8/006", lat, bcd);
    end
    test_scan(6);
  endtask

  task automatic test_busy_ignored();
    int pulses;
    int lat;
    pulses = 0;
    p = 8'd100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c >= 2 && c <= 7) begin
        p = 8'd42;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    checks++;
    if (pulses !== 1 || bcd !== 12'h100) begin
      errors++;
      $display("[TB] FAIL busy_ignored got pulses=%0d bcd=%h want 1/100", pulses, bcd);
    end
    run_conv(8'd42, lat);
    checks++;
    if (lat !== 8 || bcd !== 12'h042) begin
      errors++;
      $display("[TB] FAIL conv_42 got lat=%0d bcd=%h want 8/042", lat, bcd);
    end
  endtask

  task automatic test_reset_mid_conv();
    int pulses;
    int lat;
    pulses = 0;
    p = 8'd200;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, bcd} !== {1'b1, 1'b0, 12'h000}) begin
      errors++;
      $display("[TB] FAIL reset_mid got rdy=%b ov=%b bcd=%h want 1/0/000", in_ready, out_valid, bcd);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL reset_abort got %0d out_valid pulses want 0", pulses);
    end
    run_conv(8'd37, lat);
    checks++;
    if (lat !== 8 || bcd !== 12'h037) begin
      errors++;
      $display("[TB] FAIL conv_37 got lat=%0d bcd=%h want 8/037", lat, bcd);
    end
  endtask

  task automatic test_scan_order();
    int lat;
    run_conv(8'd123, lat);
    checks++;
    if (bcd !== 12'h123) begin
      errors++;
      $display("[TB] FAIL conv_123 got bcd=%h want 123", bcd);
    end
    test_scan(123);
  endtask

  task automatic test_back_to_back();
    int lat;
    int v;
    for (int n = 0; n < 12; n++) begin
      v = int'($urandom_range(0, 255));
      run_conv(8'(v), lat);
      checks++;
      if (lat !== 8 || bcd !== model_bcd(v)) begin
        errors++;
        $display("[TB] FAIL b2b_%0d got lat=%0d bcd=%h want 8/%h", v, lat, bcd, model_bcd(v));
      end
    end
    v = int'($urandom_range(10, 99));
    run_conv(8'(v), lat);
    test_scan(v);
  endtask

  initial begin
    seg_table[0] = 7'b1000000;
    seg_table[1] = 7'b1111001;
    seg_table[2] = 7'b0100100;
    seg_table[3] = 7'b0110000;
    seg_table[4] = 7'b0011001;
    seg_table[5] = 7'b0010010;
    seg_table[6] = 7'b0000010;
    seg_table[7] = 7'b1111000;
    seg_table[8] = 7'b0000000;
    seg_table[9] = 7'b0010000;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    p = 8'h00;
    test_reset();
    test_handshake_latency();
    test_zero_blanking();
    test_max_and_small();
    test_busy_ignored();
    test_reset_mid_conv();
    test_scan_order();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
